// File: rtl/cnn_loader_pkg.sv
// ============================================================================
// Module      : cnn_loader_pkg
// Description : Shared constants and state encodings for the CNN image loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_loader_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } loader_state_e;

    typedef enum logic [2:0] {
        IDLE_RX = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ============================================================================
// Module      : uart_rx_byte
// Description : UART byte receiver with input synchroniser and mid-bit
//               sampling. Define PARITY_EN for 8E1 framing (default 8N1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk__,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_err
);
    import cnn_loader_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_err_q, par_err_d;
    logic             valid_q, valid_d;
    logic [7:0]       byte_q, byte_d;
    logic             err_q, err_d;
    logic             w_rx;

    assign w_rx = sync_q[1];

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[0], uart_rx};
        prev_d    = w_rx;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        valid_d   = 1'b0;
        byte_d    = byte_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE_RX: begin
                if (prev_q && !w_rx) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (cnt_q == C_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = w_rx ? IDLE_RX : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == C_FULL) begin
                    cnt_d   = '0;
                    shift_d = {w_rx, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == C_FULL) begin
                    cnt_d     = '0;
                    par_err_d = ^{shift_q, w_rx};
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == C_FULL) begin
                    cnt_d     = '0;
                    par_err_d = 1'b0;
                    state_d   = IDLE_RX;
                    if (w_rx && !par_err_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE_RX;
        endcase
    end

    always_ff @(posedge clk__ or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE_RX;
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            valid_q   <= 1'b0;
            byte_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            valid_q   <= valid_d;
            byte_q    <= byte_d;
            err_q     <= err_d;
        end
    end

    assign rx_valid = valid_q;
    assign rx_byte  = byte_q;
    assign rx_err   = err_q;

endmodule

`default_nettype wire

// File: rtl/cnn_img_loader.sv
// ============================================================================
// Module      : cnn_img_loader
// Description : Receives a framed, checksummed image over UART and writes it
//               into the CNN image BRAM. PARITY_EN selects 8E1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_img_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 784,
    parameter int ADDR_W       = 13,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic              clk__,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              busy,
    output logic              img_valid,
    output logic              load_done,
    output logic              err_frame,
    output logic              err_csum,
    output logic              err_timeout
);
    import cnn_loader_pkg::*;

    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [TMO_W-1:0]  C_TMO  = TMO_W'(TIMEOUT_CLKS);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk__   (clk__),
        .rst     (rst),
        .uart_rx (uart_rx),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .rx_err  (rx_err)
    );

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic              busy_q, busy_d;
    logic              img_valid_q, img_valid_d;
    logic              load_done_q, load_done_d;
    logic              err_frame_q, err_frame_d;
    logic              err_csum_q, err_csum_d;
    logic              err_timeout_q, err_timeout_d;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        csum_d        = csum_q;
        tmo_d         = tmo_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        busy_d        = busy_q;
        img_valid_d   = img_valid_q;
        load_done_d   = 1'b0;
        err_frame_d   = err_frame_q | rx_err;
        err_csum_d    = err_csum_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            IDLE: begin
                if (rx_valid && rx_byte == SOF_BYTE) begin
                    state_d       = LOAD;
                    count_d       = '0;
                    csum_d        = '0;
                    tmo_d         = C_TMO;
                    busy_d        = 1'b1;
                    img_valid_d   = 1'b0;
                    err_frame_d   = 1'b0;
                    err_csum_d    = 1'b0;
                    err_timeout_d = 1'b0;
                end
            end
            LOAD, CHECK: begin
                if (rx_valid) begin
                    tmo_d = C_TMO;
                    if (state_q == LOAD) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = count_q;
                        mem_din_d  = rx_byte;
                        csum_d     = csum_q + rx_byte;
                        if (count_q == C_LAST) begin
                            state_d = CHECK;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end else begin
                        if (rx_byte == csum_q) begin
                            img_valid_d = 1'b1;
                            load_done_d = 1'b1;
                        end else begin
                            err_csum_d = 1'b1;
                        end
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (rx_err) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (tmo_q == '0) begin
                    err_timeout_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = IDLE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk__ or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            csum_q        <= '0;
            tmo_q         <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            busy_q        <= 1'b0;
            img_valid_q   <= 1'b0;
            load_done_q   <= 1'b0;
            err_frame_q   <= 1'b0;
            err_csum_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            csum_q        <= csum_d;
            tmo_q         <= tmo_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            busy_q        <= busy_d;
            img_valid_q   <= img_valid_d;
            load_done_q   <= load_done_d;
            err_frame_q   <= err_frame_d;
            err_csum_q    <= err_csum_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign busy        = busy_q;
    assign img_valid   = img_valid_q;
    assign load_done   = load_done_q;
    assign err_frame   = err_frame_q;
    assign err_csum    = err_csum_q;
    assign err_timeout = err_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_cnn_img_loader.sv
// ============================================================================
// Module      : tb_cnn_img_loader
// Description : Scoreboard bench for cnn_img_loader with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_img_loader;

    localparam int CPB    = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 13;
    localparam int TMO    = 2000;

    typedef logic [7:0] bytes_t[$];
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        din;
    } wr_t;

    logic              clk__   = 1'b0;
    logic              rst     = 1'b1;
    logic              uart_rx = 1'b1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              busy, img_valid, load_done;
    logic              err_frame, err_csum, err_timeout;

    always #5 clk__ = ~clk__;

    cnn_img_loader #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk__      (clk__),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .busy       (busy),
        .img_valid  (img_valid),
        .load_done  (load_done),
        .err_frame  (err_frame),
        .err_csum   (err_csum),
        .err_timeout(err_timeout)
    );

    int  checks = 0;
    int  errors = 0;
    wr_t exp_wr[$];
    int  exp_done = 0;

    // Frame-level reference model state
    bit         m_busy, m_valid, m_ef, m_ec, m_et;
    int         m_idx;
    logic [7:0] m_sum;

    function automatic void check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_valid = 0; m_ef = 0; m_ec = 0; m_et = 0;
        m_idx = 0; m_sum = 8'h00;
        exp_wr.delete();
        exp_done = 0;
    endfunction

    function automatic void model_byte(logic [7:0] b);
        if (!m_busy) begin
            if (b == 8'hA5) begin
                m_busy = 1; m_valid = 0; m_idx = 0; m_sum = 8'h00;
                m_ef = 0; m_ec = 0; m_et = 0;
            end
        end else if (m_idx < DEPTH) begin
            exp_wr.push_back({ADDR_W'(m_idx), b});
            m_sum = m_sum + b;
            m_idx++;
        end else begin
            if (b == m_sum) begin
                m_valid = 1;
                exp_done++;
            end else begin
                m_ec = 1;
            end
            m_busy = 0;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk__);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk__);
        end
`ifdef PARITY_EN
        uart_rx = ^b;
        repeat (CPB) @(negedge clk__);
`endif
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk__);
        uart_rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        model_byte(b);
        send_byte(b, 1'b1);
        repeat ($urandom_range(0, 50)) @(negedge clk__);
    endtask

    task automatic send_frame(input bytes_t bs);
        foreach (bs[i]) send_good(bs[i]);
    endtask

    task automatic check_status(input string tag);
        repeat (20) @(negedge clk__);
        check({tag, "_busy"},        int'(busy),        int'(m_busy));
        check({tag, "_img_valid"},   int'(img_valid),   int'(m_valid));
        check({tag, "_err_frame"},   int'(err_frame),   int'(m_ef));
        check({tag, "_err_csum"},    int'(err_csum),    int'(m_ec));
        check({tag, "_err_timeout"}, int'(err_timeout), int'(m_et));
        check({tag, "_wr_pending"},  exp_wr.size(),     0);
        check({tag, "_done_pending"}, exp_done,         0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_we"},      int'(mem_we),      0);
        check({tag, "_mem_addr"},    int'(mem_addr),    0);
        check({tag, "_mem_din"},     int'(mem_din),     0);
        check({tag, "_busy"},        int'(busy),        0);
        check({tag, "_img_valid"},   int'(img_valid),   0);
        check({tag, "_load_done"},   int'(load_done),   0);
        check({tag, "_err_frame"},   int'(err_frame),   0);
        check({tag, "_err_csum"},    int'(err_csum),    0);
        check({tag, "_err_timeout"}, int'(err_timeout), 0);
    endtask

    // Monitor: every write strobe and load_done pulse is matched against the model
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk__);
            if (!rst) begin
                if (mem_we) begin
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %0d din %0h, no write expected at %0t",
                                 mem_addr, mem_din, $time);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", int'(mem_addr), int'(e.addr));
                        check("wr_din",  int'(mem_din),  int'(e.din));
                    end
                end
                if (load_done) begin
                    check("load_done_expected", int'(exp_done > 0), 1);
                    if (exp_done > 0) exp_done--;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bytes_t     fr;
        logic [7:0] s, g;
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (5) @(negedge clk__);
        rst = 1'b0;
        repeat (5) @(negedge clk__);

        fr = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        send_frame(fr);
        check_status("good");

        fr = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        send_frame(fr);
        check_status("badcsum");

        fr = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hE9};
        send_frame(fr);
        check_status("a5data_bad");
        fr = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h94};
        send_frame(fr);
        check_status("a5data_good");

        fr = '{8'hA5, 8'h01, 8'h02};
        send_frame(fr);
        repeat (1500) @(negedge clk__);
        check("busy_before_timeout", int'(busy), 1);
        repeat (800) @(negedge clk__);
        m_busy = 0;
        m_et   = 1;
        check_status("timeout");
        fr = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
        send_frame(fr);
        check_status("after_timeout");

        fr = '{8'hA5, 8'h01};
        send_frame(fr);
        m_ef   = 1;
        m_busy = 0;
        send_byte(8'h3C, 1'b0);
        check_status("frame_err");
        fr = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00};
        send_frame(fr);
        check_status("after_frame_err");

        send_good(8'hA5);
        uart_rx = 1'b0;
        repeat (3 * CPB) @(negedge clk__);
        #2;
        rst = 1'b1;
        model_reset();
        uart_rx = 1'b1;
        #1;
        check_all_zero("midreset");
        repeat (5) @(negedge clk__);
        rst = 1'b0;
        repeat (5) @(negedge clk__);
        check_status("after_reset_idle");
        fr = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        send_frame(fr);
        check_status("after_reset_load");

        for (int f = 0; f < 6; f++) begin
            fr.delete();
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            fr.push_back(g);
            fr.push_back(8'hA5);
            s = 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                g = 8'($urandom_range(0, 255));
                fr.push_back(g);
                s = s + g;
            end
            fr.push_back(($urandom_range(0, 1) == 1) ? s : (s ^ 8'h01));
            send_frame(fr);
            check_status("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
